dibit_frame_sync: RTL and testbench

Frame synchroniser directly downstream of the differential decoder. Consumes the decoded dibit stream {b2k, b2k_plus1} and searches it for a fixed sync word, allowing a configurable number of bit errors. Runs a HUNT/VERIFY/LOCK state machine and, while locked, packs payload dibits into bytes with start/end-of-frame markers for the deframer.

---
 rtl/dibit_sync_pkg.sv | 22 ++
 rtl/dibit_sync_correlator.sv | 30 +++
 rtl/dibit_frame_sync.sv | 175 +++++++++++++++++
 tb/tb_dibit_frame_sync.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dibit_sync_pkg.sv
// Shared types and defaults for the dibit frame synchroniser.
package dibit_sync_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    VERIFY = 2'd1,
    LOCK   = 2'd2
  } sync_state_e;

  localparam int unsigned DEF_SYNC_LEN       = 32;
  localparam logic [31:0] DEF_SYNC_WORD      = 32'h1ACF_FC1D;
  localparam int unsigned DEF_MAX_ERR        = 2;
  localparam int unsigned DEF_PAYLOAD_DIBITS = 64;
  localparam int unsigned DEF_VERIFY_HITS    = 2;
  localparam int unsigned DEF_LOCK_MISS      = 3;

  // Width of an error counter able to hold 0..n_bits.
  function automatic int unsigned popcnt_width(input int unsigned n_bits);
    return $clog2(n_bits + 1);
  endfunction

endpackage

// File: rtl/dibit_sync_correlator.sv
// Combinational sync-word correlator: flags a window whose Hamming distance
// to the reference word is within the error budget. Kept separate so an
// inverted-word search can reuse it with a different reference.
module dibit_sync_correlator
  import dibit_sync_pkg::*;
#(
  parameter int unsigned           SYNC_LEN  = DEF_SYNC_LEN,
  parameter logic [SYNC_LEN-1:0]   SYNC_WORD = DEF_SYNC_WORD,
  parameter int unsigned           MAX_ERR   = DEF_MAX_ERR
) (
  input  logic [SYNC_LEN-1:0] win,
  output logic                match
);

  localparam int unsigned PCW = popcnt_width(SYNC_LEN);

  logic [SYNC_LEN-1:0] diff_s;
  logic [PCW-1:0]      err_cnt_s;

  // Count differing bits and compare against the tolerance.
  always_comb begin
    diff_s    = win ^ SYNC_WORD;
    err_cnt_s = '0;
    for (int i = 0; i < SYNC_LEN; i++) begin
      err_cnt_s = err_cnt_s + {{(PCW-1){1'b0}}, diff_s[i]};
    end
    match = (err_cnt_s <= PCW'(MAX_ERR));
  end

endmodule

// File: rtl/dibit_frame_sync.sv
// Dibit frame synchroniser: HUNT/VERIFY/LOCK sync search on the decoded dibit
// stream, packing payload dibits into bytes with frame markers while locked.
module dibit_frame_sync
  import dibit_sync_pkg::*;
#(
  parameter int unsigned         SYNC_LEN       = DEF_SYNC_LEN,
  parameter logic [SYNC_LEN-1:0] SYNC_WORD      = DEF_SYNC_WORD,
  parameter int unsigned         MAX_ERR        = DEF_MAX_ERR,
  parameter int unsigned         PAYLOAD_DIBITS = DEF_PAYLOAD_DIBITS,
  parameter int unsigned         VERIFY_HITS    = DEF_VERIFY_HITS,
  parameter int unsigned         LOCK_MISS      = DEF_LOCK_MISS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [1:0] in_dibit,
  output logic       out_valid,
  output logic [7:0] out_byte,
  output logic       out_sof,
  output logic       out_eof,
  output logic       locked,
  output logic       sync_hit,
  output logic       sync_miss
);

  localparam int unsigned FRAME  = PAYLOAD_DIBITS + SYNC_LEN / 2;
  localparam int unsigned POS_W  = $clog2(FRAME);
  localparam int unsigned HIT_W  = $clog2(VERIFY_HITS + 1);
  localparam int unsigned MISS_W = $clog2(LOCK_MISS + 1);

  localparam logic [POS_W-1:0]  POS_LAST       = POS_W'(FRAME - 1);
  localparam logic [POS_W-1:0]  POS_PAY        = POS_W'(PAYLOAD_DIBITS);
  localparam logic [POS_W-1:0]  POS_FIRST_BYTE = POS_W'(3);
  localparam logic [POS_W-1:0]  POS_LAST_BYTE  = POS_W'(PAYLOAD_DIBITS - 1);
  localparam logic [HIT_W-1:0]  HITS_TGT       = HIT_W'(VERIFY_HITS);
  localparam logic [MISS_W-1:0] MISS_TGT       = MISS_W'(LOCK_MISS);

  sync_state_e         state_r;
  logic [SYNC_LEN-1:0] win_r;
  logic [POS_W-1:0]    pos_r;
  logic [HIT_W-1:0]    hits_r;
  logic [MISS_W-1:0]   misses_r;
  logic [5:0]          acc_r;
  logic                emit_r;
  logic                out_valid_r;
  logic [7:0]          out_byte_r;
  logic                out_sof_r;
  logic                out_eof_r;
  logic                locked_r;
  logic                sync_hit_r;
  logic                sync_miss_r;

  logic [SYNC_LEN-1:0] win_next_s;
  logic                match_s;
  logic                at_sync_s;
  logic                emit_frame_s;
  logic                byte_done_s;

  // The match decision includes the dibit arriving this cycle.
  assign win_next_s = {win_r[SYNC_LEN-3:0], in_dibit};

  dibit_sync_correlator #(
    .SYNC_LEN  (SYNC_LEN),
    .SYNC_WORD (SYNC_WORD),
    .MAX_ERR   (MAX_ERR)
  ) u_corr (
    .win   (win_next_s),
    .match (match_s)
  );

  assign at_sync_s    = (pos_r == POS_LAST);
  // Emission is decided once per frame, at payload dibit 0.
  assign emit_frame_s = (pos_r == '0) ? (state_r == LOCK) : emit_r;
  assign byte_done_s  = in_valid && (state_r != HUNT) && (pos_r < POS_PAY) &&
                        (pos_r[1:0] == 2'b11) && emit_frame_s;

  // Sync state machine, frame position tracking and byte packing.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= HUNT;
      win_r       <= '0;
      pos_r       <= '0;
      hits_r      <= '0;
      misses_r    <= '0;
      acc_r       <= 6'd0;
      emit_r      <= 1'b0;
      out_valid_r <= 1'b0;
      out_byte_r  <= 8'd0;
      out_sof_r   <= 1'b0;
      out_eof_r   <= 1'b0;
      locked_r    <= 1'b0;
      sync_hit_r  <= 1'b0;
      sync_miss_r <= 1'b0;
    end else begin
      out_valid_r <= 1'b0;
      out_sof_r   <= 1'b0;
      out_eof_r   <= 1'b0;
      sync_hit_r  <= 1'b0;
      sync_miss_r <= 1'b0;
      if (in_valid) begin
        win_r <= win_next_s;
        acc_r <= {acc_r[3:0], in_dibit};
        if (byte_done_s) begin
          out_valid_r <= 1'b1;
          out_byte_r  <= {acc_r, in_dibit};
          out_sof_r   <= (pos_r == POS_FIRST_BYTE);
          out_eof_r   <= (pos_r == POS_LAST_BYTE);
        end
        if ((state_r != HUNT) && (pos_r == '0)) begin
          emit_r <= (state_r == LOCK);
        end
        case (state_r)
          HUNT: begin
            if (match_s) begin
              state_r    <= VERIFY;
              pos_r      <= '0;
              hits_r     <= '0;
              sync_hit_r <= 1'b1;
            end
          end
          VERIFY: begin
            if (at_sync_s) begin
              pos_r <= '0;
              if (match_s) begin
                sync_hit_r <= 1'b1;
                hits_r     <= hits_r + HIT_W'(1'b1);
                if ((hits_r + HIT_W'(1'b1)) == HITS_TGT) begin
                  state_r  <= LOCK;
                  misses_r <= '0;
                  locked_r <= 1'b1;
                end
              end else begin
                sync_miss_r <= 1'b1;
                state_r     <= HUNT;
              end
            end else begin
              pos_r <= pos_r + POS_W'(1'b1);
            end
          end
          LOCK: begin
            if (at_sync_s) begin
              pos_r <= '0;
              if (match_s) begin
                sync_hit_r <= 1'b1;
                misses_r   <= '0;
              end else begin
                sync_miss_r <= 1'b1;
                misses_r    <= misses_r + MISS_W'(1'b1);
                if ((misses_r + MISS_W'(1'b1)) == MISS_TGT) begin
                  state_r  <= HUNT;
                  locked_r <= 1'b0;
                end
              end
            end else begin
              pos_r <= pos_r + POS_W'(1'b1);
            end
          end
          default: begin
            state_r  <= HUNT;
            locked_r <= 1'b0;
          end
        endcase
      end
    end
  end

  assign out_valid = out_valid_r;
  assign out_byte  = out_byte_r;
  assign out_sof   = out_sof_r;
  assign out_eof   = out_eof_r;
  assign locked    = locked_r;
  assign sync_hit  = sync_hit_r;
  assign sync_miss = sync_miss_r;

endmodule

// File: tb/tb_dibit_frame_sync.sv
// Directed self-checking bench for dibit_frame_sync.
module tb_dibit_frame_sync;

  localparam logic [31:0] SYNC = 32'h1ACF_FC1D;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [1:0] in_dibit;
  logic       out_valid;
  logic [7:0] out_byte;
  logic       out_sof;
  logic       out_eof;
  logic       locked;
  logic       sync_hit;
  logic       sync_miss;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int hit_cnt = 0;
  int miss_cnt = 0;
  int marker_viol = 0;
  bit gaps = 1'b0;

  logic [7:0] got_b[$];
  bit         got_sof[$];
  bit         got_eof[$];
  logic [7:0] cnt_b[16];
  logic [7:0] emb_b[16];

  always #5 clk = ~clk;

  dibit_frame_sync dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_dibit  (in_dibit),
    .out_valid (out_valid),
    .out_byte  (out_byte),
    .out_sof   (out_sof),
    .out_eof   (out_eof),
    .locked    (locked),
    .sync_hit  (sync_hit),
    .sync_miss (sync_miss)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock edge, then record what the DUT produced for it.
  task automatic tick();
    @(posedge clk);
    #1;
    if (out_valid) begin
      got_b.push_back(out_byte);
      got_sof.push_back(out_sof);
      got_eof.push_back(out_eof);
    end
    if (sync_hit) hit_cnt++;
    if (sync_miss) miss_cnt++;
    if ((out_sof || out_eof) && !out_valid) marker_viol++;
  endtask

  task automatic send(input logic [1:0] d);
    if (gaps) begin
      while ($urandom_range(0, 1) == 1) begin
        in_valid = 1'b0;
        in_dibit = 2'($urandom_range(0, 3));
        tick();
      end
    end
    in_valid = 1'b1;
    in_dibit = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 15; i >= 0; i--) send(w[2*i +: 2]);
  endtask

  task automatic send_frame(input logic [7:0] b[16]);
    for (int k = 0; k < 16; k++)
      for (int i = 3; i >= 0; i--) send(b[k][2*i +: 2]);
  endtask

  task automatic check_frame(input string tag, input int base, input logic [7:0] exp[16]);
    int bad = 0;
    chk({tag, "_n"}, 32'(got_b.size()), 32'(base + 16));
    if (got_b.size() < base + 16) bad = 99;
    else begin
      for (int i = 0; i < 16; i++) begin
        if (got_b[base+i] !== exp[i] || got_sof[base+i] !== (i == 0) ||
            got_eof[base+i] !== (i == 15)) bad++;
      end
    end
    chk({tag, "_bytes"}, 32'(bad), 32'd0);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_dibit = 2'd0;
    tick();
    rst_n = 1'b1;
    hit_cnt = 0;
    miss_cnt = 0;
    marker_viol = 0;
    got_b.delete();
    got_sof.delete();
    got_eof.delete();
  endtask

  // Three sync words with counting payload in between; ends locked.
  task automatic acquire(input string p);
    send_word(SYNC);
    chk({p, "_acq_s1_hit"}, 32'(sync_hit), 32'd1);
    send_frame(cnt_b);
    send_word(SYNC);
    send_frame(cnt_b);
    send_word(SYNC);
    chk({p, "_acq_locked"}, 32'(locked), 32'd1);
  endtask

  task automatic run_clean(input string p);
    do_reset();
    send_word(SYNC);
    chk({p, "_s1_hit"}, 32'(sync_hit), 32'd1);
    chk({p, "_s1_locked"}, 32'(locked), 32'd0);
    send_frame(cnt_b);
    send_word(SYNC);
    chk({p, "_s2_hit"}, 32'(sync_hit), 32'd1);
    chk({p, "_s2_locked"}, 32'(locked), 32'd0);
    send_frame(cnt_b);
    send_word(SYNC);
    chk({p, "_s3_hit"}, 32'(sync_hit), 32'd1);
    chk({p, "_s3_locked"}, 32'(locked), 32'd1);
    chk({p, "_no_early_bytes"}, 32'(got_b.size()), 32'd0);
    send_frame(cnt_b);
    check_frame({p, "_f3"}, 0, cnt_b);
    send_word(SYNC);
    chk({p, "_hits"}, 32'(hit_cnt), 32'd4);
    chk({p, "_misses"}, 32'(miss_cnt), 32'd0);
    chk({p, "_markers"}, 32'(marker_viol), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    for (int i = 0; i < 16; i++) begin
      cnt_b[i] = 8'(i);
      emb_b[i] = 8'(i);
    end
    emb_b[4] = 8'h1A;
    emb_b[5] = 8'hCF;
    emb_b[6] = 8'hFC;
    emb_b[7] = 8'h1D;

    // Reset state
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_dibit = 2'd0;
    tick();
    tick();
    chk("rst_outs", {25'd0, out_valid, out_sof, out_eof, locked, sync_hit, sync_miss, 1'b0}, 32'd0);
    chk("rst_byte", 32'(out_byte), 32'd0);
    rst_n = 1'b1;

    // Clean continuous stream
    run_clean("clean");

    // Error tolerance boundary
    do_reset();
    send_word(SYNC ^ 32'h0000_0081);
    chk("err2_hit", 32'(sync_hit), 32'd1);
    chk("err2_hitcnt", 32'(hit_cnt), 32'd1);
    do_reset();
    send_word(SYNC ^ 32'h8000_0101);
    chk("err3_hit", 32'(sync_hit), 32'd0);
    chk("err3_hitcnt", 32'(hit_cnt), 32'd0);

    // Loss of lock
    do_reset();
    acquire("lol");
    send_frame(cnt_b);
    send_word(SYNC ^ 32'hFFFF_0000);
    chk("lol_m1_miss", 32'(sync_miss), 32'd1);
    chk("lol_m1_locked", 32'(locked), 32'd1);
    send_frame(cnt_b);
    check_frame("lol_f2", 16, cnt_b);
    send_word(SYNC ^ 32'hFFFF_0000);
    chk("lol_m2_miss", 32'(sync_miss), 32'd1);
    chk("lol_m2_locked", 32'(locked), 32'd1);
    send_frame(cnt_b);
    check_frame("lol_f3", 32, cnt_b);
    send_word(SYNC ^ 32'hFFFF_0000);
    chk("lol_m3_miss", 32'(sync_miss), 32'd1);
    chk("lol_m3_locked", 32'(locked), 32'd0);
    chk("lol_misscnt", 32'(miss_cnt), 32'd3);
    send_frame(cnt_b);
    chk("lol_no_more_bytes", 32'(got_b.size()), 32'd48);

    // Gappy input
    gaps = 1'b1;
    run_clean("gaps");
    gaps = 1'b0;

    // Reset mid-payload
    do_reset();
    acquire("mid");
    send(2'd0);
    send(2'd0);
    rst_n = 1'b0;
    in_valid = 1'b1;
    in_dibit = 2'd0;
    tick();
    chk("mid_rst_outs", {25'd0, out_valid, out_sof, out_eof, locked, sync_hit, sync_miss, 1'b0}, 32'd0);
    chk("mid_rst_byte", 32'(out_byte), 32'd0);
    rst_n = 1'b1;
    in_valid = 1'b0;
    send(2'd0);
    send(2'd0);
    for (int k = 1; k < 16; k++)
      for (int i = 3; i >= 0; i--) send(cnt_b[k][2*i +: 2]);
    chk("mid_no_bytes", 32'(got_b.size()), 32'd0);
    chk("mid_unlocked", 32'(locked), 32'd0);
    send_word(SYNC);
    chk("mid_reacq_s1_locked", 32'(locked), 32'd0);
    send_frame(cnt_b);
    chk("mid_reacq_no_bytes", 32'(got_b.size()), 32'd0);
    send_word(SYNC);
    send_frame(cnt_b);
    send_word(SYNC);
    chk("mid_relocked", 32'(locked), 32'd1);
    send_frame(cnt_b);
    check_frame("mid_f", 0, cnt_b);

    // False sync inside payload
    do_reset();
    acquire("fs");
    base = hit_cnt;
    send_frame(emb_b);
    chk("fs_no_hit", 32'(hit_cnt), 32'(base));
    check_frame("fs_f", 0, emb_b);
    send_word(SYNC);
    chk("fs_next_hit", 32'(sync_hit), 32'd1);
    chk("fs_next_locked", 32'(locked), 32'd1);
    send_frame(cnt_b);
    check_frame("fs_f2", 16, cnt_b);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
